// File: rtl/bp_core_lce_req_arb.sv
// bp_core_lce_req_arb
// Merges the I$ (index 0) and D$ (index 1) LCE request streams into one
// network request stream through a single-entry output buffer, using a
// round-robin arbiter with a 1-bit last-grant pointer.
//
// Optional feature: define BP_LCE_REQ_ARB_CREDIT_EN to enable the outstanding
// request credit counter. Without it, credits_full_o is tied low,
// credits_empty_o reflects an empty buffer, and credit_return_i is ignored.
//
// Handshake semantics (valid/ready on every interface):
//   - A beat moves only in a cycle where valid and ready are both high.
//   - Input side: lce_req_ready_o[i] is asserted only for the arbitration
//     winner; it never depends on the losing requester's valid.
//   - Output side: lce_req_v_o, lce_req_o and lce_req_src_o stay stable
//     until lce_req_ready_i accepts the beat.
module bp_core_lce_req_arb #(
  parameter int req_width_p = 64,
  parameter int credits_p   = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [1:0][req_width_p-1:0]  lce_req_i,
  input  logic [1:0]                   lce_req_v_i,
  output logic [1:0]                   lce_req_ready_o,
  output logic [req_width_p-1:0]       lce_req_o,
  output logic                         lce_req_v_o,
  input  logic                         lce_req_ready_i,
  output logic                         lce_req_src_o,
  input  logic                         credit_return_i,
  output logic                         credits_full_o,
  output logic                         credits_empty_o
);

  typedef enum logic {
    E_EMPTY = 1'b0,
    E_FULL  = 1'b1
  } buf_state_e;

  buf_state_e             state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic [req_width_p-1:0] data_q;
  logic                   src_q;

  logic       credit_block;
  logic       send;
  logic       can_accept;
  logic       grant0, grant1;
  logic       xfer;
  logic       xfer_src;

  // Network side: the buffer is offered only when it holds a request and
  // the credit pool is not exhausted; reset forces everything quiet.
  assign lce_req_v_o   = (state_q == E_FULL) & ~credit_block & ~reset_i;
  assign lce_req_o     = data_q;
  assign lce_req_src_o = src_q;
  assign send          = lce_req_v_o & lce_req_ready_i;

  // The buffer can take a new request if it is empty or is draining now.
  assign can_accept = ~reset_i & ((state_q == E_EMPTY) | send);

  // Round robin: the requester opposite the last grant wins a tie. Each
  // grant depends on its own valid and only on the other valid when the
  // other requester has priority.
  assign grant0 = lce_req_v_i[0] & (ptr_q  | ~lce_req_v_i[1]);
  assign grant1 = lce_req_v_i[1] & (~ptr_q | ~lce_req_v_i[0]);

  assign lce_req_ready_o = {grant1, grant0} & {2{can_accept}};
  assign xfer            = |lce_req_ready_o;
  assign xfer_src        = lce_req_ready_o[1];

  // Next-state for the buffer FSM and the last-grant pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      ptr_d = xfer_src;
    end
    case (state_q)
      E_EMPTY: if (xfer)          state_d = E_FULL;
      E_FULL:  if (send && !xfer) state_d = E_EMPTY;
      default:                    state_d = E_EMPTY;
    endcase
  end

  // Buffer FSM, pointer and held packet; reset discards any held request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= E_EMPTY;
      ptr_q   <= 1'b1;
      data_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (xfer) begin
        data_q <= lce_req_i[xfer_src];
        src_q  <= xfer_src;
      end
    end
  end

`ifdef BP_LCE_REQ_ARB_CREDIT_EN
  localparam int cnt_w_lp = $clog2(credits_p + 1);
  localparam logic [cnt_w_lp-1:0] credits_lp = cnt_w_lp'(credits_p);

  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  assign credit_block    = (cnt_q == credits_lp);
  assign credits_full_o  = credit_block & ~reset_i;
  assign credits_empty_o = reset_i | ((cnt_q == '0) & (state_q == E_EMPTY));

  // Outstanding count: a send and a return in one cycle cancel; a return
  // with nothing outstanding is dropped so the count never wraps. A send
  // cannot happen while the count is at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (send && !credit_return_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!send && credit_return_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Outstanding counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_credit_return;

  assign unused_credit_return = credit_return_i;
  assign credit_block         = 1'b0;
  assign credits_full_o       = 1'b0;
  assign credits_empty_o      = reset_i | (state_q == E_EMPTY);
`endif

endmodule

// File: tb/tb_bp_core_lce_req_arb.sv
// Testbench for bp_core_lce_req_arb: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_bp_core_lce_req_arb;

  localparam int W       = 16;
  localparam int CREDITS = 2;
`ifdef BP_LCE_REQ_ARB_CREDIT_EN
  localparam bit CREDIT_EN = 1'b1;
`else
  localparam bit CREDIT_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              reset_i;
  logic [1:0][W-1:0] lce_req_i;
  logic [1:0]        lce_req_v_i;
  logic [1:0]        lce_req_ready_o;
  logic [W-1:0]      lce_req_o;
  logic              lce_req_v_o;
  logic              lce_req_ready_i;
  logic              lce_req_src_o;
  logic              credit_return_i;
  logic              credits_full_o;
  logic              credits_empty_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bp_core_lce_req_arb #(.req_width_p(W), .credits_p(CREDITS)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .lce_req_i       (lce_req_i),
    .lce_req_v_i     (lce_req_v_i),
    .lce_req_ready_o (lce_req_ready_o),
    .lce_req_o       (lce_req_o),
    .lce_req_v_o     (lce_req_v_o),
    .lce_req_ready_i (lce_req_ready_i),
    .lce_req_src_o   (lce_req_src_o),
    .credit_return_i (credit_return_i),
    .credits_full_o  (credits_full_o),
    .credits_empty_o (credits_empty_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [W:0]   exp_q[$];   // held requests {src, data}; at most one entry
  logic [W-1:0] dut_sent[$]; // packets the DUT actually handed to the network
  int           m_cnt;       // outstanding requests
  bit           m_last;      // last granted requester

  logic [1:0] e_ready;
  bit e_v, e_full, e_empty, e_send, e_xfer, e_win;

  // Expected combinational outputs for the inputs currently applied.
  task automatic model_eval();
    bit cf;
    if (reset_i) begin
      e_ready = 2'b00; e_v = 0; e_full = 0; e_empty = 1;
      e_send = 0; e_xfer = 0; e_win = 0;
      return;
    end
    cf      = CREDIT_EN && (m_cnt == CREDITS);
    e_full  = cf;
    e_v     = (exp_q.size() == 1) && !cf;
    e_send  = e_v && lce_req_ready_i;
    e_empty = (exp_q.size() == 0) && (!CREDIT_EN || m_cnt == 0);
    if (lce_req_v_i == 2'b11) e_win = !m_last;
    else                      e_win = lce_req_v_i[1];
    e_xfer  = (lce_req_v_i != 2'b00) && (exp_q.size() == 0 || e_send);
    e_ready = e_xfer ? (2'b01 << e_win) : 2'b00;
  endtask

  // Model state update for one clock edge.
  task automatic model_tick();
    if (reset_i) begin
      exp_q.delete();
      m_cnt  = 0;
      m_last = 1'b1;
      return;
    end
    if (e_send) void'(exp_q.pop_front());
    if (e_xfer) begin
      exp_q.push_back({e_win, lce_req_i[e_win]});
      m_last = e_win;
    end
    if (CREDIT_EN) begin
      if (e_send && !credit_return_i) m_cnt++;
      else if (!e_send && credit_return_i && m_cnt > 0) m_cnt--;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    if (lce_req_v_o && lce_req_ready_i) dut_sent.push_back(lce_req_o);
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [W-1:0] d0,
                       input logic [W-1:0] d1, input logic rdy, input logic ret);
    lce_req_v_i     = v;
    lce_req_i[0]    = d0;
    lce_req_i[1]    = d1;
    lce_req_ready_i = rdy;
    credit_return_i = ret;
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    settle(); advance();
    settle(); advance();
    reset_i = 1'b0;
    dut_sent.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_i = 1'b1;
    drive(2'b11, 16'h1111, 16'h2222, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (lce_req_v_o !== 1'b0) $display("FAIL reset_v_o got=%b exp=0", lce_req_v_o);
      else n_pass++;
      n_checks++;
      if (lce_req_ready_o !== 2'b00) $display("FAIL reset_ready got=%b exp=00", lce_req_ready_o);
      else n_pass++;
      n_checks++;
      if (credits_full_o !== 1'b0) $display("FAIL reset_full got=%b exp=0", credits_full_o);
      else n_pass++;
      n_checks++;
      if (credits_empty_o !== 1'b1) $display("FAIL reset_empty got=%b exp=1", credits_empty_o);
      else n_pass++;
      advance();
    end
    reset_i = 1'b0;
    dut_sent.delete();
  endtask

  task automatic test_alternate();
    logic [W-1:0] exp_d;
    logic         exp_s;
    apply_reset();
    drive(2'b11, 16'h000A, 16'h000B, 1'b1, 1'b1);
    settle();
    n_checks++;
    if (lce_req_ready_o !== 2'b01) $display("FAIL alt_first_grant got=%b exp=01", lce_req_ready_o);
    else n_pass++;
    advance();
    for (int k = 1; k <= 6; k++) begin
      settle();
      exp_s = (k % 2 == 0);
      exp_d = exp_s ? 16'h000B : 16'h000A;
      n_checks++;
      if (lce_req_v_o !== 1'b1 || lce_req_o !== exp_d || lce_req_src_o !== exp_s)
        $display("FAIL alt_send%0d got v=%b d=%h s=%b exp v=1 d=%h s=%b",
                 k, lce_req_v_o, lce_req_o, lce_req_src_o, exp_d, exp_s);
      else n_pass++;
      n_checks++;
      if (lce_req_ready_o !== e_ready) $display("FAIL alt_ready%0d got=%b exp=%b", k, lce_req_ready_o, e_ready);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_hold();
    apply_reset();
    drive(2'b01, 16'h1234, 16'h0000, 1'b0, 1'b0);
    settle(); advance();
    drive(2'b11, 16'h5555, 16'h6666, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      settle();
      n_checks++;
      if (lce_req_v_o !== 1'b1 || lce_req_o !== 16'h1234 || lce_req_src_o !== 1'b0)
        $display("FAIL hold_out%0d got v=%b d=%h s=%b exp v=1 d=1234 s=0",
                 k, lce_req_v_o, lce_req_o, lce_req_src_o);
      else n_pass++;
      n_checks++;
      if (lce_req_ready_o !== 2'b00) $display("FAIL hold_ready%0d got=%b exp=00", k, lce_req_ready_o);
      else n_pass++;
      advance();
    end
    lce_req_ready_i = 1'b1;
    settle();
    n_checks++;
    if (lce_req_ready_o !== 2'b10) $display("FAIL hold_release_ready got=%b exp=10", lce_req_ready_o);
    else n_pass++;
    advance();
    settle();
    n_checks++;
    if (lce_req_o !== 16'h6666 || lce_req_src_o !== 1'b1)
      $display("FAIL hold_next got d=%h s=%b exp d=6666 s=1", lce_req_o, lce_req_src_o);
    else n_pass++;
    advance();
  endtask

`ifdef BP_LCE_REQ_ARB_CREDIT_EN
  task automatic test_credits();
    apply_reset();
    drive(2'b10, '0, 16'h0031, 1'b1, 1'b0);
    settle(); advance();
    drive(2'b10, '0, 16'h0032, 1'b1, 1'b0);
    settle(); advance();
    drive(2'b10, '0, 16'h0033, 1'b1, 1'b0);
    settle(); advance();
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    settle();
    n_checks++;
    if (credits_full_o !== 1'b1 || lce_req_v_o !== 1'b0 || lce_req_o !== 16'h0033)
      $display("FAIL credit_stall got full=%b v=%b d=%h exp full=1 v=0 d=0033",
               credits_full_o, lce_req_v_o, lce_req_o);
    else n_pass++;
    advance();
    credit_return_i = 1'b1;
    settle();
    n_checks++;
    if (lce_req_v_o !== 1'b0) $display("FAIL credit_stall2 got v=%b exp=0", lce_req_v_o);
    else n_pass++;
    advance();
    credit_return_i = 1'b0;
    settle();
    n_checks++;
    if (lce_req_v_o !== 1'b1 || lce_req_o !== 16'h0033 || lce_req_src_o !== 1'b1 || credits_full_o !== 1'b0)
      $display("FAIL credit_resume got v=%b d=%h s=%b full=%b exp v=1 d=0033 s=1 full=0",
               lce_req_v_o, lce_req_o, lce_req_src_o, credits_full_o);
    else n_pass++;
    advance();
    settle();
    n_checks++;
    if (credits_full_o !== 1'b1) $display("FAIL credit_refull got=%b exp=1", credits_full_o);
    else n_pass++;
    advance();
  endtask

  task automatic test_credit_edge();
    apply_reset();
    drive(2'b00, '0, '0, 1'b1, 1'b1);
    settle(); advance();
    drive(2'b01, 16'h0041, '0, 1'b1, 1'b0);
    settle();
    n_checks++;
    if (credits_empty_o !== 1'b1 || credits_full_o !== 1'b0)
      $display("FAIL ret_at_zero got empty=%b full=%b exp empty=1 full=0", credits_empty_o, credits_full_o);
    else n_pass++;
    advance();
    drive(2'b01, 16'h0042, '0, 1'b1, 1'b0);
    settle(); advance();
    drive(2'b00, '0, '0, 1'b1, 1'b1);
    settle(); advance();
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    settle();
    n_checks++;
    if (credits_empty_o !== 1'b0 || credits_full_o !== 1'b0)
      $display("FAIL send_and_ret got empty=%b full=%b exp empty=0 full=0", credits_empty_o, credits_full_o);
    else n_pass++;
    drive(2'b01, 16'h0043, '0, 1'b1, 1'b0);
    settle(); advance();
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    settle(); advance();
    settle();
    n_checks++;
    if (credits_full_o !== 1'b1) $display("FAIL count_kept got full=%b exp=1", credits_full_o);
    else n_pass++;
    advance();
  endtask
`endif

  task automatic test_reset_mid();
    int hits;
    apply_reset();
    drive(2'b01, 16'h0077, '0, 1'b0, 1'b0);
    settle(); advance();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    settle();
    n_checks++;
    if (lce_req_v_o !== 1'b1 || lce_req_o !== 16'h0077)
      $display("FAIL mid_loaded got v=%b d=%h exp v=1 d=0077", lce_req_v_o, lce_req_o);
    else n_pass++;
    reset_i = 1'b1;
    settle(); advance();
    reset_i = 1'b0;
    lce_req_ready_i = 1'b1;
    settle();
    n_checks++;
    if (lce_req_v_o !== 1'b0 || credits_empty_o !== 1'b1)
      $display("FAIL mid_after got v=%b empty=%b exp v=0 empty=1", lce_req_v_o, credits_empty_o);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      settle(); advance();
    end
    hits = 0;
    foreach (dut_sent[i]) if (dut_sent[i] == 16'h0077) hits++;
    n_checks++;
    if (hits !== 0) $display("FAIL mid_discard got sends=%0d exp=0", hits);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      reset_i = ($urandom_range(0, 59) == 0);
      drive(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      settle();
      n_checks++;
      if (lce_req_ready_o !== e_ready) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, lce_req_ready_o, e_ready);
      else n_pass++;
      n_checks++;
      if (lce_req_v_o !== e_v) $display("FAIL rnd_v c=%0d got=%b exp=%b", c, lce_req_v_o, e_v);
      else n_pass++;
      n_checks++;
      if (credits_full_o !== e_full || credits_empty_o !== e_empty)
        $display("FAIL rnd_credit c=%0d got full=%b empty=%b exp full=%b empty=%b",
                 c, credits_full_o, credits_empty_o, e_full, e_empty);
      else n_pass++;
      if (e_v) begin
        n_checks++;
        if (lce_req_o !== exp_q[0][W-1:0] || lce_req_src_o !== exp_q[0][W])
          $display("FAIL rnd_data c=%0d got d=%h s=%b exp d=%h s=%b",
                   c, lce_req_o, lce_req_src_o, exp_q[0][W-1:0], exp_q[0][W]);
        else n_pass++;
      end
      advance();
    end
    reset_i = 1'b0;
  endtask

  // ---------------- sequence / final report ----------------
  initial begin
    reset_i = 1'b1;
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    m_cnt  = 0;
    m_last = 1'b1;
    @(negedge clk);
    test_reset();
    test_alternate();
    test_hold();
`ifdef BP_LCE_REQ_ARB_CREDIT_EN
    test_credits();
    test_credit_edge();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
